wb_port_arbiter: RTL and testbench

//  Schedules the single register-file write port between the pipeline W stage and
//  a secondary long-latency result source (multi-cycle mul/div, uncached load return).
//  W-stage writes always win. Secondary results wait in a small FIFO until a free slot.

---
 rtl/wb_port_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: W-stage writes win, secondary long-latency
// results queue in a small in-order FIFO and request a W bubble when starved.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     RegWriteW,
  input  logic [4:0]               WriteRegW,
  input  logic [31:0]              WriteDataW,
  input  logic                     SecValid,
  input  logic [4:0]               SecReg,
  input  logic [31:0]              SecData,
  output logic                     SecReady,
  output logic                     RFWrite,
  output logic [4:0]               RFWriteReg,
  output logic [31:0]              RFWriteData,
  output logic                     StallReq,
  input  logic [4:0]               QueryRegA,
  input  logic [4:0]               QueryRegB,
  output logic                     QueryHitA,
  output logic                     QueryHitB,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, PENDING, FORCE} state_t;

  state_t          state, stateNext;
  logic [4:0]      fifoReg  [DEPTH];
  logic [31:0]     fifoData [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [SW-1:0]   starveCnt, starveNext;
  logic [CW-1:0]   countNext;
  logic [DEPTH-1:0] entryValid;
  logic [PW-1:0]   slotOff;
  logic            push, pop, full, nonEmpty, wLost;

  assign full     = (Count == CW'(DEPTH));
  assign nonEmpty = (Count != '0);
  assign SecReady = !full;
  assign push     = SecValid && SecReady;
  assign pop      = !RegWriteW && nonEmpty;
  assign wLost    = RegWriteW && nonEmpty;
  assign countNext = Count + CW'(push) - CW'(pop);
  assign StallReq  = (state == FORCE);

  // Port select; a destination of r0 still consumes the slot but never writes
  always_comb begin
    RFWrite     = 1'b0;
    RFWriteReg  = '0;
    RFWriteData = '0;
    if (RegWriteW) begin
      RFWriteReg  = WriteRegW;
      RFWriteData = WriteDataW;
      RFWrite     = Rst_n && (WriteRegW != 5'd0);
    end else if (nonEmpty) begin
      RFWriteReg  = fifoReg[head];
      RFWriteData = fifoData[head];
      RFWrite     = Rst_n && (fifoReg[head] != 5'd0);
    end
  end

  always_comb begin
    entryValid = '0;
    slotOff    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slotOff       = PW'(i) - head;
      entryValid[i] = ({1'b0, slotOff} < Count);
    end
  end

  always_comb begin
    QueryHitA = 1'b0;
    QueryHitB = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i] && (fifoReg[i] == QueryRegA) && (QueryRegA != 5'd0)) QueryHitA = 1'b1;
      if (entryValid[i] && (fifoReg[i] == QueryRegB) && (QueryRegB != 5'd0)) QueryHitB = 1'b1;
    end
  end

  always_comb begin
    starveNext = starveCnt;
    if (pop || !nonEmpty || state == IDLE) begin
      starveNext = '0;
    end else if (RegWriteW && starveCnt < SW'(STARVE_LIMIT)) begin
      starveNext = starveCnt + SW'(1);
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (push) stateNext = PENDING;
      end
      PENDING: begin
        if (pop && countNext == '0) begin
          stateNext = IDLE;
        end else if ((wLost && starveCnt >= SW'(STARVE_LIMIT - 1)) || (full && SecValid)) begin
          stateNext = FORCE;
        end
      end
      FORCE: begin
        if (pop) stateNext = (countNext == '0) ? IDLE : PENDING;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      head      <= '0;
      tail      <= '0;
      Count     <= '0;
      starveCnt <= '0;
      state     <= IDLE;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      Count     <= countNext;
      starveCnt <= starveNext;
      state     <= stateNext;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge Clk) begin
    if (push) begin
      fifoReg[tail]  <= SecReg;
      fifoData[tail] <= SecData;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstN;
  logic          regWriteW;
  logic [4:0]    writeRegW;
  logic [31:0]   writeDataW;
  logic          secValid;
  logic [4:0]    secReg;
  logic [31:0]   secData;
  logic          secReady;
  logic          rfWrite;
  logic [4:0]    rfWriteReg;
  logic [31:0]   rfWriteData;
  logic          stallReq;
  logic [4:0]    queryRegA, queryRegB;
  logic          queryHitA, queryHitB;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .Clk(clk), .Rst_n(rstN),
    .RegWriteW(regWriteW), .WriteRegW(writeRegW), .WriteDataW(writeDataW),
    .SecValid(secValid), .SecReg(secReg), .SecData(secData), .SecReady(secReady),
    .RFWrite(rfWrite), .RFWriteReg(rfWriteReg), .RFWriteData(rfWriteData),
    .StallReq(stallReq),
    .QueryRegA(queryRegA), .QueryRegB(queryRegB),
    .QueryHitA(queryHitA), .QueryHitB(queryHitB),
    .Count(count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending secondary results in arrival order
  logic [36:0] q[$];
  int          starve;
  bit          stallM;
  bit          accepted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    starve   = 0;
    stallM   = 1'b0;
    accepted = 1'b0;
  endtask

  task automatic compareAll();
    logic        expW;
    logic [4:0]  expR;
    logic [31:0] expD;
    logic        hA, hB;
    expW = 1'b0; expR = '0; expD = '0; hA = 1'b0; hB = 1'b0;
    if (regWriteW) begin
      expR = writeRegW;
      expD = writeDataW;
      expW = rstN && (writeRegW != 5'd0);
    end else if (q.size() > 0) begin
      expR = q[0][36:32];
      expD = q[0][31:0];
      expW = (expR != 5'd0);
    end
    foreach (q[i]) begin
      if (q[i][36:32] == queryRegA && queryRegA != 5'd0) hA = 1'b1;
      if (q[i][36:32] == queryRegB && queryRegB != 5'd0) hB = 1'b1;
    end
    chk("RFWrite", 32'(rfWrite), 32'(expW));
    chk("RFWriteReg", 32'(rfWriteReg), 32'(expR));
    chk("RFWriteData", rfWriteData, expD);
    chk("Count", 32'(count), q.size());
    chk("SecReady", 32'(secReady), 32'(q.size() < DEPTH));
    chk("StallReq", 32'(stallReq), 32'(stallM));
    chk("QueryHitA", 32'(queryHitA), 32'(hA));
    chk("QueryHitB", 32'(queryHitB), 32'(hB));
  endtask

  task automatic modelUpdate();
    int n, nAfter;
    bit doPop, doPush, lost;
    n      = q.size();
    doPop  = !regWriteW && n > 0;
    doPush = secValid && n < DEPTH;
    lost   = regWriteW && n > 0;
    nAfter = n + int'(doPush) - int'(doPop);
    if (stallM) stallM = !doPop;
    else stallM = (n > 0) && (nAfter > 0) &&
                  ((lost && starve >= LIMIT - 1) || (n == DEPTH && secValid));
    if (doPop || n == 0) starve = 0;
    else if (regWriteW && starve < LIMIT) starve++;
    if (doPop) void'(q.pop_front());
    if (doPush) q.push_back({secReg, secData});
    accepted = doPush;
  endtask

  task automatic sample();
    @(negedge clk);
    compareAll();
  endtask

  task automatic advance();
    @(posedge clk);
    if (rstN) modelUpdate();
    else accepted = 1'b0;
    #1;
    if (accepted) secValid = 1'b0;
    accepted = 1'b0;
  endtask

  task automatic send(input logic [4:0] r, input logic [31:0] d);
    secValid = 1'b1;
    secReg   = r;
    secData  = d;
  endtask

  task automatic midCycleReset();
    #2;
    rstN = 1'b0;
    secValid = 1'b0;
    modelReset();
    #1;
    compareAll();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0; regWriteW = 1'b0; writeRegW = '0; writeDataW = '0;
    secValid = 1'b0; secReg = '0; secData = '0; queryRegA = '0; queryRegB = '0;
    modelReset();
    sample();
    chk("resetCount", 32'(count), 0);
    chk("resetStall", 32'(stallReq), 0);
    advance();
    rstN = 1'b1;
    sample();
    chk("readyAfterReset", 32'(secReady), 1);
    advance();

    // W-stage only
    regWriteW = 1'b1; writeRegW = 5'd5; writeDataW = 32'h1234;
    sample();
    chk("t1Write", 32'(rfWrite), 1);
    chk("t1Reg", 32'(rfWriteReg), 5);
    chk("t1Data", rfWriteData, 32'h1234);
    chk("t1Count", 32'(count), 0);
    advance();

    // Secondary with W idle
    regWriteW = 1'b0;
    send(5'd9, 32'hCAFE);
    sample();
    advance();
    sample();
    chk("t2Write", 32'(rfWrite), 1);
    chk("t2Reg", 32'(rfWriteReg), 9);
    chk("t2Data", rfWriteData, 32'hCAFE);
    chk("t2Count", 32'(count), 1);
    advance();
    sample();
    chk("t2Drained", 32'(count), 0);
    advance();

    // Starvation
    regWriteW = 1'b1; writeRegW = 5'd1; writeDataW = 32'h77;
    send(5'd3, 32'hAA);
    sample();
    advance();
    for (int k = 1; k <= 10; k++) begin
      sample();
      if (k == 8) chk("t3StallLow", 32'(stallReq), 0);
      if (k == 9) chk("t3StallHigh", 32'(stallReq), 1);
      advance();
    end
    regWriteW = 1'b0;
    sample();
    chk("t3Reg", 32'(rfWriteReg), 3);
    chk("t3Data", rfWriteData, 32'hAA);
    chk("t3StallHeld", 32'(stallReq), 1);
    advance();
    sample();
    chk("t3StallDrop", 32'(stallReq), 0);
    chk("t3Count", 32'(count), 0);
    advance();

    // Full FIFO with a held fifth request
    regWriteW = 1'b1; writeRegW = 5'd2; writeDataW = 32'h22;
    for (int i = 0; i < 4; i++) begin
      send(5'(10 + i), 32'h100 + 32'(i));
      sample();
      advance();
    end
    send(5'd14, 32'h114);
    sample();
    chk("t4Count", 32'(count), 4);
    chk("t4Ready", 32'(secReady), 0);
    advance();
    sample();
    chk("t4Stall", 32'(stallReq), 1);
    advance();
    regWriteW = 1'b0;
    sample();
    chk("t4PopReg", 32'(rfWriteReg), 10);
    chk("t4NoReady", 32'(secReady), 0);
    advance();
    sample();
    chk("t4AfterPop", 32'(count), 3);
    chk("t4ReadyAgain", 32'(secReady), 1);
    chk("t4StallOff", 32'(stallReq), 0);
    advance();
    sample();
    chk("t4PushPop", 32'(count), 3);
    chk("t4Order", 32'(rfWriteReg), 12);
    advance();
    repeat (4) begin
      sample();
      advance();
    end

    // r0 entry and hazard queries
    regWriteW = 1'b1; writeRegW = 5'd4; writeDataW = 32'h44;
    send(5'd0, 32'hFF);
    sample();
    advance();
    send(5'd7, 32'h11);
    sample();
    advance();
    queryRegA = 5'd7; queryRegB = 5'd7;
    sample();
    chk("t5HitA", 32'(queryHitA), 1);
    chk("t5HitB", 32'(queryHitB), 1);
    advance();
    queryRegA = 5'd0;
    sample();
    chk("t5MissR0", 32'(queryHitA), 0);
    advance();
    regWriteW = 1'b0;
    sample();
    chk("t5R0NoWrite", 32'(rfWrite), 0);
    chk("t5Count", 32'(count), 2);
    advance();
    sample();
    chk("t5Write", 32'(rfWrite), 1);
    chk("t5Reg", 32'(rfWriteReg), 7);
    chk("t5Data", rfWriteData, 32'h11);
    advance();

    // Reset during starvation
    regWriteW = 1'b1; writeRegW = 5'd4;
    for (int i = 0; i < 3; i++) begin
      send(5'(20 + i), 32'h200 + 32'(i));
      sample();
      advance();
    end
    repeat (8) begin
      sample();
      advance();
    end
    sample();
    chk("t6Count", 32'(count), 3);
    chk("t6Stall", 32'(stallReq), 1);
    midCycleReset();
    chk("t6RstCount", 32'(count), 0);
    chk("t6RstStall", 32'(stallReq), 0);
    chk("t6RstWrite", 32'(rfWrite), 0);
    advance();
    rstN = 1'b1;
    regWriteW = 1'b0;
    repeat (3) begin
      sample();
      chk("t6NoOldWrite", 32'(rfWrite), 0);
      advance();
    end

    // Randomized traffic
    begin
      int busyPct;
      busyPct = 50;
      for (int c = 0; c < 3000; c++) begin
        if (c % 60 == 0) busyPct = (c / 60) % 3 == 0 ? 95 : ((c / 60) % 3 == 1 ? 50 : 20);
        regWriteW  = 1'($urandom_range(99) < busyPct);
        if (stallM && $urandom_range(3) != 0) regWriteW = 1'b0;
        writeRegW  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
        writeDataW = $urandom;
        if (!secValid && $urandom_range(99) < 45)
          send(($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)), $urandom);
        if (q.size() > 0 && $urandom_range(1) == 1)
          queryRegA = q[$urandom_range(q.size() - 1)][36:32];
        else
          queryRegA = 5'($urandom_range(31));
        queryRegB = 5'($urandom_range(31));
        sample();
        if ($urandom_range(399) == 0) begin
          midCycleReset();
          advance();
          rstN = 1'b1;
        end else begin
          advance();
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
